// File: rtl/axis_detector_packer_if.sv
// AXI4-Stream style bundle (tdata/tvalid/tready/tlast) with a width parameter.
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
// Used for both the 128-bit event input and the 32-bit word output.
interface axis_detector_packer_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_detector_packer.sv
// Buffers 128-bit {time,hits} detector events in a FIFO and serializes each into four 32-bit
// AXI4-Stream words, closing a packet with tlast every cfg_data events.
// Ports: aclk/aresetn (sync, active-low), cfg_data (events per packet, 0 means 1),
// s_axis (event input; tready is tied high, events arriving while full are dropped),
// m_axis (word output, full valid/ready), sts_data (saturating dropped-event count).
// Latency: 2 cycles from event strobe to word 0 when idle; 4 cycles per event at full rate.
module axis_detector_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [15:0]                   cfg_data,
  axis_detector_packer_if.slave         s_axis,
  axis_detector_packer_if.master        m_axis,
  output logic [31:0]                   sts_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [127:0]  mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          drop;
  logic          pop;
  logic [127:0]  head;

  logic [127:0]  hold;
  logic [1:0]    idx;
  logic [1:0]    idx_inc;
  logic [15:0]   ev_cnt;
  logic [15:0]   pkt_len;
  logic [15:0]   cfg_len;
  logic          xfer;
  logic          last_event;
  logic          pkt_start;

  logic [31:0]   tdata_r;
  logic          tvalid_r;
  logic          tlast_r;

  // The input stream has no flow control; overflow is handled by dropping.
  assign s_axis.tready = 1'b1;

  logic unused_s_tlast;
  assign unused_s_tlast = s_axis.tlast;

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tlast  = tlast_r;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never rescues an event.
  assign push = s_axis.tvalid & ~fifo_full;
  assign drop = s_axis.tvalid & fifo_full;

  assign xfer       = tvalid_r & m_axis.tready;
  assign idx_inc    = idx + 2'd1;
  assign cfg_len    = (cfg_data == 16'd0) ? 16'd1 : cfg_data;
  assign last_event = (ev_cnt == pkt_len - 16'd1);
  // A pop in SEND follows word 3, so the next event opens a packet exactly when
  // the current one closes; in IDLE the counter already tells us.
  assign pkt_start  = (state == ST_SEND) ? last_event : (ev_cnt == 16'd0);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer && idx == 2'd3) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_axis.tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hold     <= '0;
      idx      <= 2'd0;
      ev_cnt   <= 16'd0;
      pkt_len  <= 16'd1;
      tdata_r  <= 32'd0;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      sts_data <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop && sts_data != 32'hFFFF_FFFF) begin
        sts_data <= sts_data + 32'd1;
      end
      if (xfer && idx == 2'd3) begin
        ev_cnt <= last_event ? 16'd0 : ev_cnt + 16'd1;
      end

      if (pop) begin
        hold     <= head;
        idx      <= 2'd0;
        tdata_r  <= head[31:0];
        tvalid_r <= 1'b1;
        tlast_r  <= 1'b0;
        if (pkt_start) begin
          pkt_len <= cfg_len;
        end
      end else if (xfer) begin
        if (idx == 2'd3) begin
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end else begin
          idx     <= idx_inc;
          tdata_r <= hold[{idx_inc, 5'd0} +: 32];
          // Only word 3 of the packet's final event carries tlast.
          tlast_r <= (idx_inc == 2'd3) && last_event;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_detector_packer.sv
// Testbench for axis_detector_packer: directed event vectors, an event-level reference
// model compared against the outputs every cycle, and literal expectations on the
// captured word stream for each scenario.
module tb_axis_detector_packer;

  localparam int DEPTH = 16;

  logic        aclk;
  logic        aresetn;
  logic [15:0] cfg;
  logic [31:0] sts_data;

  axis_detector_packer_if #(.W(128)) s_if ();
  axis_detector_packer_if #(.W(32))  m_if ();

  axis_detector_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cfg_data (cfg),
    .s_axis   (s_if.slave),
    .m_axis   (m_if.master),
    .sts_data (sts_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;
  int mode = 0;   // 0: tready high, 1: pattern 1,0,0,1, 2: tready low
  int cyc  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model at event granularity: a queue of buffered events, the event
  // being sent with the number of its words still outstanding, and packet bookkeeping.
  logic [127:0] m_q[$];
  logic [127:0] m_cur;
  int           m_rem;
  int           m_cnt;
  int           m_len;
  logic [31:0]  m_drops;

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_q.delete();
      m_cur   = '0;
      m_rem   = 0;
      m_cnt   = 0;
      m_len   = 1;
      m_drops = '0;
    end else begin
      automatic bit was_full  = (m_q.size() == DEPTH);
      automatic bit was_empty = (m_q.size() == 0);
      if (m_rem > 0 && m_if.tready) begin
        if (m_rem == 1) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == m_len) m_cnt = 0;
        end
        m_rem = m_rem - 1;
      end
      if (m_rem == 0 && !was_empty) begin
        m_cur = m_q.pop_front();
        m_rem = 4;
        if (m_cnt == 0) m_len = (cfg == 16'd0) ? 1 : int'(cfg);
      end
      if (s_if.tvalid) begin
        if (was_full) begin
          if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        end else begin
          m_q.push_back(s_if.tdata);
        end
      end
    end
  end

  // Accepted-word log for the literal checks.
  logic [31:0] log_d[$];
  logic        log_l[$];

  always @(negedge aclk) begin
    if (started) begin
      chk("tvalid", m_if.tvalid, m_rem > 0);
      chk("sts_data", sts_data, m_drops);
      if (m_rem > 0) begin
        chk("tdata", m_if.tdata, m_cur[32*(4-m_rem) +: 32]);
        chk("tlast", m_if.tlast, (m_rem == 1) && (m_cnt == m_len - 1));
      end
      if (m_if.tvalid && m_if.tready) begin
        log_d.push_back(m_if.tdata);
        log_l.push_back(m_if.tlast);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    case (mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_if.tready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [127:0] ev);
    s_if.tdata  = ev;
    s_if.tvalid = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(m_rem == 0 && m_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: drain did not finish within %0d cycles", nm, budget);
    end
  endtask

  task automatic chk_log(input string nm, input int nwords, input int last0, input int last1);
    chk({nm, "_count"}, log_d.size(), nwords);
    for (int i = 0; i < log_d.size() && i < nwords; i++) begin
      chk({nm, "_tlast"}, log_l[i], (i == last0) || (i == last1));
    end
  endtask

  function automatic logic [127:0] t4_ev(input int e);
    return {32'h4000_0000 + e, 32'h3000_0000 + e, 32'h2000_0000 + e, 32'h1000_0000 + e};
  endfunction

  localparam logic [127:0] EV1 = {64'h0000_0001_0000_0002, 64'h8000_0000_0000_0001};

  initial begin
    logic [31:0] w1[4];
    w1[0] = 32'h0000_0001; w1[1] = 32'h8000_0000; w1[2] = 32'h0000_0002; w1[3] = 32'h0000_0001;

    aresetn     = 1'b0;
    cfg         = 16'd1;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    tick();
    started = 1'b1;
    tick();
    @(negedge aclk);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_sts", sts_data, 0);
    chk("s_tready", s_if.tready, 1);
    aresetn = 1'b1;
    tick();

    // Single event, first-word latency and word order.
    log_d.delete(); log_l.delete();
    send(EV1);
    @(negedge aclk);
    chk("t1_lat_k", m_if.tvalid, 0);
    @(negedge aclk);
    chk("t1_lat_k1_vld", m_if.tvalid, 1);
    chk("t1_lat_k1_dat", m_if.tdata, 32'h0000_0001);
    wait_idle("t1", 50);
    chk_log("t1", 4, 3, -1);
    for (int i = 0; i < 4 && i < log_d.size(); i++) chk("t1_word", log_d[i], w1[i]);

    // Same event under a stalling consumer.
    log_d.delete(); log_l.delete();
    mode = 1;
    tick();
    send(EV1);
    wait_idle("t2", 80);
    chk_log("t2", 4, 3, -1);
    for (int i = 0; i < 4 && i < log_d.size(); i++) chk("t2_word", log_d[i], w1[i]);
    mode = 0;
    tick();

    // cfg=3, seven spaced events: tlast on words 12 and 24 only.
    do_reset();
    log_d.delete(); log_l.delete();
    cfg = 16'd3;
    for (int e = 0; e < 7; e++) begin
      send({32'hE0 + e, 32'hD0 + e, 32'hC0 + e, 32'hB0 + e});
      repeat (5) tick();
    end
    wait_idle("t3", 60);
    chk_log("t3", 28, 11, 23);
    chk("t3_w4", log_d.size() > 4 ? log_d[4] : 32'hx, 32'hB1);

    // cfg=0 closes every event; then cfg 1->4 while an event is in flight.
    do_reset();
    log_d.delete(); log_l.delete();
    cfg = 16'd0;
    send(EV1);
    send(EV1);
    wait_idle("t5a", 60);
    chk_log("t5a", 8, 3, 7);
    log_d.delete(); log_l.delete();
    cfg = 16'd1;
    send(EV1);
    repeat (2) tick();
    cfg = 16'd4;
    for (int e = 0; e < 4; e++) send(t4_ev(e));
    wait_idle("t5b", 80);
    chk_log("t5b", 20, 3, 19);

    // Overflow: tready low, 20 back-to-back events into a 16-deep FIFO.
    do_reset();
    log_d.delete(); log_l.delete();
    cfg  = 16'd4;
    mode = 2;
    tick();
    for (int e = 0; e < 20; e++) send(t4_ev(e));
    @(negedge aclk);
    chk("t4_drops", sts_data, 3);
    mode = 0;
    tick();
    wait_idle("t4", 200);
    chk("t4_count", log_d.size(), 68);
    for (int e = 0; e < 17; e++) begin
      for (int w = 0; w < 4; w++) begin
        if (4 * e + w < log_d.size()) begin
          chk("t4_word", log_d[4*e+w], 32'h1000_0000 * (w + 1) + e);
          chk("t4_tlast", log_l[4*e+w], (w == 3) && (e % 4 == 3));
        end
      end
    end

    // Reset while word 2 of an event is presented; drop count is nonzero before it.
    cfg = 16'd1;
    tick();
    log_d.delete(); log_l.delete();
    send({64'h0000_0003_0000_0004, 64'h0000_0005_0000_0006});
    repeat (4) @(negedge aclk);
    chk("t6_word2", m_if.tdata, 32'h0000_0004);
    chk("t6_sts_before", sts_data, 3);
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    chk("t6_rst_tvalid", m_if.tvalid, 0);
    chk("t6_rst_tdata", m_if.tdata, 0);
    chk("t6_rst_tlast", m_if.tlast, 0);
    chk("t6_rst_sts", sts_data, 0);
    aresetn = 1'b1;
    tick();
    log_d.delete(); log_l.delete();
    send(EV1);
    wait_idle("t6", 50);
    chk_log("t6", 4, 3, -1);
    for (int i = 0; i < 4 && i < log_d.size(); i++) chk("t6_word", log_d[i], w1[i]);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_detector_packer.md
Name: axis_detector_packer

Overview:
Downstream stage of the detector reader. Accepts 128-bit {time[63:0], hits[63:0]} event beats on a valid-only stream (no backpressure), buffers them in a small FIFO, and serializes each event into four 32-bit AXI4-Stream words for the DMA writer. Packets are delimited with tlast every cfg_data events. Events arriving while the FIFO is full are dropped and counted.

Parameters:
FIFO_DEPTH, 16, number of 128-bit event entries; power of two, 4..256.

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
cfg_data  input  16  events per packet; 0 treated as 1
s_axis_tdata  input  128  event: [127:64] timestamp, [63:0] hit mask
s_axis_tvalid  input  1  event strobe; one event per high cycle; no tready
m_axis_tdata  output  32  serialized event word
m_axis_tvalid  output  1  output word valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  last word of packet
sts_data  output  32  dropped-event count, saturating

Behaviour:
- Reset values: aresetn sampled low at a rising edge of aclk clears all state.
  - m_axis_tdata = 0, m_axis_tvalid = 0, m_axis_tlast = 0, sts_data = 0.
  - FIFO emptied, serializer IDLE, packet event counter 0.
- Reset mid-operation: the partially sent event and packet are discarded. The next word after reset starts a fresh packet.
- FIFO write:
  - s_axis_tvalid=1 and FIFO not full: store s_axis_tdata.
  - s_axis_tvalid=1 and FIFO full: discard the event; sts_data += 1, saturating at 0xFFFFFFFF.
  - "Full" is evaluated on the occupancy at the start of the cycle. A pop in the same cycle does not rescue the incoming event.
  - Simultaneous push and pop when not full: occupancy unchanged.
- FIFO capacity is exactly FIFO_DEPTH events. The serializer holding register is an additional stage that is not counted in capacity.
- Serializer states:
  - IDLE: if FIFO not empty, pop the head into a 128-bit holding register, set word index 0, assert m_axis_tvalid, go to SEND.
  - SEND: present the word selected by the index.
    - Word 0 = hits[31:0], word 1 = hits[63:32], word 2 = time[31:0], word 3 = time[63:32].
    - m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered outputs and stay stable while tvalid=1 and tready=0.
    - On tvalid&tready with index<3: index+1.
    - On tvalid&tready with index=3 and FIFO not empty: pop the next event in the same cycle (no bubble), index=0.
    - On tvalid&tready with index=3 and FIFO empty: m_axis_tvalid=0, go to IDLE.
- Latency: event strobed at edge k into an empty FIFO with serializer IDLE is written at edge k, popped at edge k+1, and word 0 is valid after edge k+1. First-word latency is 2 cycles.
- Throughput: one event per 4 cycles with tready held high.
- Packetization:
  - Packet length N = (cfg_data==0) ? 1 : cfg_data. N is latched when word 0 of the first event of a packet is loaded; cfg changes take effect only at a packet boundary.
  - Event counter counts completed events in the packet. m_axis_tlast=1 only on word 3 of event N. Counter returns to 0 when that word is accepted.
  - tlast never appears on words 0..2.
- No timeout flush: a partial packet waits for further events.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Event counter is 16 bits.

Test Plan:
- Single event {time=64'h0000_0001_0000_0002, hits=64'h8000_0000_0000_0001}, cfg=1, tready=1 -> after 2 cycles four consecutive words 0x00000001, 0x80000000, 0x00000002, 0x00000001; tlast only on the 4th; tvalid then low.
- Same event with tready toggling 1,0,0,1,... -> words never skipped or repeated; tdata and tlast stable while stalled; still 4 words total.
- cfg=3, 7 events spaced 6 cycles apart, tready=1 -> 28 words; tlast on words 12 and 24 only; last 4 words pending with no tlast.
- FIFO_DEPTH=16, tready=0, 20 back-to-back events -> holding register takes event 0, FIFO holds 16, sts_data=3; releasing tready yields 17 events in order.
- cfg=0 -> tlast on word 3 of every event. Change cfg 1→4 mid-event -> the current packet closes at N=1 and the next packet uses N=4.
- Reset asserted for 1 cycle mid-event (word 2 pending) -> outputs 0 and sts_data=0 next cycle; a subsequent event is emitted from word 0 as a new packet.
